mem_bus_ctrl: RTL and testbench

- External memory bus controller between the mainboard core and the 8-bit external bus.
- Performs 16-bit instruction fetches from PROM as two byte reads.
- Performs 8-bit loads from RAM/flash and 8-bit stores to RAM.
- Drives promOE_, ramOE_, flashOE_ and ramWE_ with a parameterised number of wait states, and returns the fetched instruction and load data to the core with a done pulse.

---
 rtl/mem_bus_ctrl_if.sv | 32 +++
 rtl/mem_bus_ctrl.sv | 162 ++++++++++++++++
 tb/tb_mem_bus_ctrl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_ctrl_if.sv
// mem_bus_ctrl_if: core request/response and external 8-bit bus signals of the memory controller
interface mem_bus_ctrl_if;
  logic [15:0] pc;
  logic        fetch_req;
  logic        ld_req;
  logic        st_req;
  logic [15:0] mem_addr;
  logic [7:0]  st_data;
  logic        busy;
  logic        done;
  logic [15:0] instr;
  logic [7:0]  ld_data;
  logic        wr_err;
  logic [15:0] addr_out;
  logic [7:0]  bus_din;
  logic [7:0]  bus_dout;
  logic        bus_oe;
  logic        promOE_;
  logic        ramOE_;
  logic        flashOE_;
  logic        ramWE_;
  modport slave (
    input  pc, fetch_req, ld_req, st_req, mem_addr, st_data, bus_din,
    output busy, done, instr, ld_data, wr_err, addr_out, bus_dout, bus_oe,
           promOE_, ramOE_, flashOE_, ramWE_
  );
  modport master (
    output pc, fetch_req, ld_req, st_req, mem_addr, st_data, bus_din,
    input  busy, done, instr, ld_data, wr_err, addr_out, bus_dout, bus_oe,
           promOE_, ramOE_, flashOE_, ramWE_
  );
endinterface

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: PROM fetch, RAM/flash load and RAM store sequencer for an 8-bit external bus
module mem_bus_ctrl #(
  parameter int WAIT_CYCLES = 2
) (
  input logic           clk,
  input logic           rst_n,
  mem_bus_ctrl_if.slave mb
);
  typedef enum logic [2:0] {IDLE, RD_HI, RD_LO, RD_DATA, WR_SETUP, WR_PULSE, WR_HOLD, FIN} state_t;
  localparam logic [3:0] WC = 4'(WAIT_CYCLES);
  state_t      state, state_d;
  logic [3:0]  cnt, cnt_d;
  logic        pend, pend_d;
  logic [14:0] pc_q, pc_d;
  logic [7:0]  hi, hi_d, dout_d, ld_d;
  logic [15:0] addr_d, instr_d;
  logic        oe_d, prom_d, ram_d, flash_d, we_d, busy_d, done_d, err_d;
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    pend_d  = pend;
    pc_d    = pc_q;
    hi_d    = hi;
    addr_d  = mb.addr_out;
    dout_d  = mb.bus_dout;
    instr_d = mb.instr;
    ld_d    = mb.ld_data;
    oe_d    = mb.bus_oe;
    prom_d  = mb.promOE_;
    ram_d   = mb.ramOE_;
    flash_d = mb.flashOE_;
    we_d    = mb.ramWE_;
    busy_d  = mb.busy;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state)
      IDLE: begin
        if (mb.st_req | mb.ld_req | mb.fetch_req) begin
          busy_d = 1'b1;
          pend_d = mb.fetch_req & (mb.st_req | mb.ld_req);
          pc_d   = mb.pc[14:0];
        end
        if (mb.st_req) begin
          addr_d = mb.mem_addr;
          // flash is read-only: reject without touching the bus
          if (mb.mem_addr[15]) begin
            state_d = FIN;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d = WR_SETUP;
            dout_d  = mb.st_data;
            oe_d    = 1'b1;
          end
        end else if (mb.ld_req) begin
          state_d = RD_DATA;
          cnt_d   = WC;
          addr_d  = mb.mem_addr;
          ram_d   = mb.mem_addr[15];
          flash_d = ~mb.mem_addr[15];
        end else if (mb.fetch_req) begin
          state_d = RD_HI;
          cnt_d   = WC;
          addr_d  = {mb.pc[14:0], 1'b0};
          prom_d  = 1'b0;
        end
      end
      RD_HI: begin
        if (cnt == 4'd0) begin
          state_d = RD_LO;
          cnt_d   = WC;
          hi_d    = mb.bus_din;
          addr_d  = {mb.addr_out[15:1], 1'b1};
        end else cnt_d = cnt - 1'b1;
      end
      RD_LO: begin
        if (cnt == 4'd0) begin
          state_d = FIN;
          instr_d = {hi, mb.bus_din};
          prom_d  = 1'b1;
          done_d  = 1'b1;
        end else cnt_d = cnt - 1'b1;
      end
      RD_DATA: begin
        if (cnt == 4'd0) begin
          state_d = FIN;
          ld_d    = mb.bus_din;
          ram_d   = 1'b1;
          flash_d = 1'b1;
          done_d  = 1'b1;
        end else cnt_d = cnt - 1'b1;
      end
      WR_SETUP: begin
        state_d = WR_PULSE;
        cnt_d   = WC;
        we_d    = 1'b0;
      end
      WR_PULSE: begin
        if (cnt == 4'd0) begin
          state_d = WR_HOLD;
          we_d    = 1'b1;
        end else cnt_d = cnt - 1'b1;
      end
      WR_HOLD: begin
        state_d = FIN;
        oe_d    = 1'b0;
        done_d  = 1'b1;
      end
      FIN: begin
        if (pend) begin
          state_d = RD_HI;
          pend_d  = 1'b0;
          cnt_d   = WC;
          addr_d  = {pc_q, 1'b0};
          prom_d  = 1'b0;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      pend        <= 1'b0;
      pc_q        <= 15'd0;
      hi          <= 8'h00;
      mb.addr_out <= 16'h0000;
      mb.bus_dout <= 8'h00;
      mb.instr    <= 16'h0000;
      mb.ld_data  <= 8'h00;
      mb.bus_oe   <= 1'b0;
      mb.promOE_  <= 1'b1;
      mb.ramOE_   <= 1'b1;
      mb.flashOE_ <= 1'b1;
      mb.ramWE_   <= 1'b1;
      mb.busy     <= 1'b0;
      mb.done     <= 1'b0;
      mb.wr_err   <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      pend        <= pend_d;
      pc_q        <= pc_d;
      hi          <= hi_d;
      mb.addr_out <= addr_d;
      mb.bus_dout <= dout_d;
      mb.instr    <= instr_d;
      mb.ld_data  <= ld_d;
      mb.bus_oe   <= oe_d;
      mb.promOE_  <= prom_d;
      mb.ramOE_   <= ram_d;
      mb.flashOE_ <= flash_d;
      mb.ramWE_   <= we_d;
      mb.busy     <= busy_d;
      mb.done     <= done_d;
      mb.wr_err   <= err_d;
    end
  end
endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl: table-driven and scoreboard checks of mem_bus_ctrl with byte-wide PROM/RAM/flash models
module tb_mem_bus_ctrl;
  localparam int W = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  mem_bus_ctrl_if m();
  mem_bus_ctrl #(.WAIT_CYCLES(W)) dut (.clk(clk), .rst_n(rst_n), .mb(m.slave));
  logic [7:0] prom [256];
  logic [7:0] ram [256];
  logic [7:0] flash [256];
  logic [7:0] shadow [256];
  assign m.bus_din = !m.promOE_ ? prom[m.addr_out[7:0]] :
                     !m.ramOE_ ? ram[m.addr_out[7:0]] :
                     !m.flashOE_ ? flash[m.addr_out[7:0]] : 8'hFF;
  always @(posedge clk) if (!m.ramWE_) ram[m.addr_out[7:0]] <= m.bus_dout;
  typedef struct {
    bit f, l, s;
    logic [15:0] p, a;
    logic [7:0] d;
    int lat, nd, prom_n, ram_n, flash_n, we_n, oe_n;
  } vec_t;
  typedef struct {
    int kind;
    logic [15:0] val;
  } exp_t;
  exp_t q[$];
  vec_t tbl[11];
  int n_chk = 0, n_fail = 0;
  int cyc, lat, done_c, prom_c, ram_c, flash_c, we_c, oe_c;
  logic [15:0] a_first, a_last, cur_a, last_instr;
  logic [7:0] cur_d, last_ld;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask
  task automatic step();
    int nl;
    exp_t e;
    @(negedge clk);
    cyc++;
    if (rst_n) begin
      nl = (m.promOE_ ? 0 : 1) + (m.ramOE_ ? 0 : 1) + (m.flashOE_ ? 0 : 1) + (m.ramWE_ ? 0 : 1);
      if (nl != 0) chk("strobe_excl", nl, 1);
      if (!m.promOE_) begin
        prom_c++;
        if (prom_c == 1) a_first = m.addr_out;
        a_last = m.addr_out;
      end
      if (!m.ramOE_) ram_c++;
      if (!m.flashOE_) flash_c++;
      if (m.bus_oe) begin
        oe_c++;
        chk("bus_dout", m.bus_dout, cur_d);
      end
      if (!m.ramWE_) begin
        we_c++;
        chk("we_addr", m.addr_out, cur_a);
      end
      if (q.size() != 0) chk("busy_held", m.busy, 1);
    end
    if (m.done) begin
      done_c++;
      if (lat < 0) lat = cyc;
      if (q.size() == 0) chk("unexpected_done", q.size(), 1);
      else begin
        e = q.pop_front();
        chk("wr_err", m.wr_err, e.kind == 2 ? e.val : 16'h0);
        if (e.kind == 0) begin
          chk("instr", m.instr, e.val);
          last_instr = e.val;
        end else if (e.kind == 1) begin
          chk("ld_data", m.ld_data, e.val[7:0]);
          last_ld = e.val[7:0];
        end
      end
    end
  endtask
  task automatic req(input bit f, input bit l, input bit s, input logic [15:0] p,
                     input logic [15:0] a, input logic [7:0] d);
    exp_t e;
    m.fetch_req = f;
    m.ld_req = l;
    m.st_req = s;
    m.pc = p;
    m.mem_addr = a;
    m.st_data = d;
    cur_a = a;
    cur_d = d;
    if (s) begin
      e = '{kind: 2, val: {15'h0, a[15]}};
      q.push_back(e);
      if (!a[15]) shadow[a[7:0]] = d;
    end else if (l) begin
      e = '{kind: 1, val: {8'h00, a[15] ? flash[a[7:0]] : shadow[a[7:0]]}};
      q.push_back(e);
    end
    if (f) begin
      e = '{kind: 0, val: {prom[{p[6:0], 1'b0}], prom[{p[6:0], 1'b1}]}};
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    m.fetch_req = 1'b0;
    m.ld_req = 1'b0;
    m.st_req = 1'b0;
    cyc = 0;
  endtask
  task automatic clear_counts();
    lat = -1;
    done_c = 0;
    prom_c = 0;
    ram_c = 0;
    flash_c = 0;
    we_c = 0;
    oe_c = 0;
  endtask
  task automatic run(input vec_t v);
    clear_counts();
    req(v.f, v.l, v.s, v.p, v.a, v.d);
    for (int i = 0; i < 200 && q.size() != 0; i++) step();
    chk("timeout_queue", q.size(), 0);
    step();
    chk("latency", lat, v.lat);
    chk("done_count", done_c, v.nd);
    chk("promOE_cycles", prom_c, v.prom_n);
    chk("ramOE_cycles", ram_c, v.ram_n);
    chk("flashOE_cycles", flash_c, v.flash_n);
    chk("ramWE_cycles", we_c, v.we_n);
    chk("bus_oe_cycles", oe_c, v.oe_n);
    chk("idle_outputs", {m.busy, m.done, m.wr_err, m.bus_oe, m.promOE_, m.ramOE_, m.flashOE_, m.ramWE_}, 8'h0F);
    chk("instr_hold", m.instr, last_instr);
    chk("ld_hold", m.ld_data, last_ld);
    if (v.prom_n > 0) begin
      chk("fetch_addr_hi", a_first, {v.p[14:0], 1'b0});
      chk("fetch_addr_lo", a_last, {v.p[14:0], 1'b1});
    end
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    vec_t v;
    for (int i = 0; i < 256; i++) begin
      prom[i] = 8'($urandom);
      flash[i] = 8'($urandom);
      ram[i] = 8'($urandom);
      shadow[i] = ram[i];
    end
    prom[6] = 8'hA5;
    prom[7] = 8'h3C;
    flash[8'h10] = 8'h77;
    tbl[0]  = '{1, 0, 0, 16'h0003, 16'h0000, 8'h00, 7, 1, 6, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 0, 16'h0000, 16'h8010, 8'h00, 4, 1, 0, 0, 3, 0, 0};
    tbl[2]  = '{0, 0, 1, 16'h0000, 16'h0042, 8'h5A, 6, 1, 0, 0, 0, 3, 5};
    tbl[3]  = '{0, 1, 0, 16'h0000, 16'h0042, 8'h00, 4, 1, 0, 3, 0, 0, 0};
    tbl[4]  = '{0, 0, 1, 16'h0000, 16'hC000, 8'h99, 1, 1, 0, 0, 0, 0, 0};
    tbl[5]  = '{1, 0, 0, 16'h8010, 16'h0000, 8'h00, 7, 1, 6, 0, 0, 0, 0};
    tbl[6]  = '{0, 1, 0, 16'h0000, 16'h8000, 8'h00, 4, 1, 0, 0, 3, 0, 0};
    tbl[7]  = '{1, 0, 1, 16'h0000, 16'h0001, 8'hE7, 6, 2, 6, 0, 0, 3, 5};
    tbl[8]  = '{1, 1, 0, 16'h0003, 16'h0042, 8'h00, 4, 2, 6, 3, 0, 0, 0};
    tbl[9]  = '{1, 1, 1, 16'h0001, 16'h0007, 8'hC3, 6, 2, 6, 0, 0, 3, 5};
    tbl[10] = '{0, 1, 0, 16'h0000, 16'h0001, 8'h00, 4, 1, 0, 3, 0, 0, 0};
    m.fetch_req = 1'b0;
    m.ld_req = 1'b0;
    m.st_req = 1'b0;
    m.pc = 16'h0;
    m.mem_addr = 16'h0;
    m.st_data = 8'h0;
    last_instr = 16'h0;
    last_ld = 8'h0;
    cyc = 0;
    clear_counts();
    repeat (2) @(negedge clk);
    chk("reset_ctrl", {m.busy, m.done, m.wr_err, m.bus_oe, m.promOE_, m.ramOE_, m.flashOE_, m.ramWE_}, 8'h0F);
    chk("reset_data", {m.instr, m.ld_data, m.addr_out, m.bus_dout}, 48'h0);
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 11; i++) run(tbl[i]);
    // a fetch request while a load is in flight must be dropped
    clear_counts();
    req(0, 1, 0, 16'h0, 16'h8010, 8'h00);
    step();
    m.fetch_req = 1'b1;
    m.pc = 16'h0003;
    step();
    m.fetch_req = 1'b0;
    for (int i = 0; i < 200 && q.size() != 0; i++) step();
    repeat (12) step();
    chk("busy_ignore_done", done_c, 1);
    chk("busy_ignore_prom", prom_c, 0);
    // reset in the middle of a RAM write pulse
    clear_counts();
    req(0, 0, 1, 16'h0, 16'h0050, 8'h11);
    for (int i = 0; i < 20 && m.ramWE_; i++) step();
    chk("we_seen", m.ramWE_, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_abort", {m.ramWE_, m.bus_oe, m.busy, m.done}, 4'b1000);
    chk("rst_regs", {m.instr, m.ld_data}, 24'h0);
    q.delete();
    last_instr = 16'h0;
    last_ld = 8'h0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    chk("rst_no_done", done_c, 0);
    v = '{1, 0, 0, 16'h0005, 16'h0000, 8'h00, 7, 1, 6, 0, 0, 0, 0};
    run(v);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
